// File: rtl/tm1638_device_responder.sv
// tm1638_device_responder
// Device-side (slave) end of a TM1638 STB/CLK/DIO serial link. Decodes host
// command bytes, holds the 16-byte display RAM plus display-control state and
// returns four key-scan bytes when the host issues a read command.
//
// Parameters:
//   SYNC_STAGES      flops per input synchronizer (>= 2)
// Ports:
//   clk, rst         system clock (>= 8x sio_clk), synchronous active-high reset
//   sio_clk          host serial clock (async)
//   sio_stb          host strobe, active low (async)
//   sio_data_in      host DIO as seen by the device (async)
//   sio_data_out     device DIO drive value (0 whenever not enabled)
//   sio_data_out_en  device drives DIO (read phase only)
//   key_scan         key bytes K0..K3, byte n = key_scan[8n+7:8n]
//   display_ram      RAM address n = display_ram[8n+7:8n]
//   display_on       display-control bit 3
//   brightness       display-control bits 2:0
//   cmd_error        one-clk pulse for a command byte with bits[7:6] = 00
//   busy             synchronized strobe is low
// Build option:
//   TM1638_RESPONDER_KEY_LATCH_EN  snapshot key_scan when the read command
//   decodes; otherwise each key byte is sampled live on its first-bit fall.

module tm1638_device_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sio_clk,
    input  logic         sio_stb,
    input  logic         sio_data_in,
    output logic         sio_data_out,
    output logic         sio_data_out_en,
    input  logic [31:0]  key_scan,
    output logic [127:0] display_ram,
    output logic         display_on,
    output logic [2:0]   brightness,
    output logic         cmd_error,
    output logic         busy
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA, S_IGNORE} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] clk_sync, stb_sync, din_sync;
    logic       clk_prev, stb_prev;
    logic       clk_s, stb_s, din_s;
    logic       clk_rise, clk_fall, stb_rise, stb_fall;

    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] byte_val;
    logic       byte_done, cmd_done, wr_en, rd_fall;
    logic [3:0] ptr;
    logic       fixed_mode;
    logic [7:0] ram [16];
    logic [2:0] key_idx;
    logic [2:0] rd_bit;
    logic [6:0] rd_shift;
    logic [7:0] cur_key;
    logic [31:0] key_src;
    logic       out_en, data_bit;

    // Input synchronizers plus one edge-detect flop. Idle levels (clk/stb high)
    // are the reset values so leaving reset does not fake a strobe edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '1;
            stb_sync <= '1;
            din_sync <= '0;
            clk_prev <= 1'b1;
            stb_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], sio_clk};
            stb_sync <= {stb_sync[SYNC_STAGES-2:0], sio_stb};
            din_sync <= {din_sync[SYNC_STAGES-2:0], sio_data_in};
            clk_prev <= clk_sync[SYNC_STAGES-1];
            stb_prev <= stb_sync[SYNC_STAGES-1];
        end
    end

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign stb_s    = stb_sync[SYNC_STAGES-1];
    assign din_s    = din_sync[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_prev;
    assign clk_fall = ~clk_s & clk_prev;
    assign stb_rise = stb_s & ~stb_prev;
    assign stb_fall = ~stb_s & stb_prev;
    assign busy     = ~stb_s;

    // LSB-first: the newest bit enters at the top of the byte.
    assign byte_val  = {din_s, rx_shift};
    assign byte_done = clk_rise && (bit_cnt == 3'd7);

`ifdef TM1638_RESPONDER_KEY_LATCH_EN
    logic [31:0] key_snap;
    always_ff @(posedge clk) begin
        if (rst)
            key_snap <= '0;
        else if (cmd_done && byte_val[7:6] == 2'b01 && byte_val[1])
            key_snap <= key_scan;
    end
    assign key_src = key_snap;
`else
    assign key_src = key_scan;
`endif

    always_comb begin
        cur_key = 8'h00;
        case (key_idx)
            3'd0:    cur_key = key_src[7:0];
            3'd1:    cur_key = key_src[15:8];
            3'd2:    cur_key = key_src[23:16];
            3'd3:    cur_key = key_src[31:24];
            default: cur_key = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Strobe edges override everything, so a byte whose 8th rise coincides
    // with the strobe rise is dropped.
    always_comb begin
        state_next = state;
        cmd_done   = 1'b0;
        wr_en      = 1'b0;
        rd_fall    = 1'b0;
        if (stb_rise) begin
            state_next = S_IDLE;
        end else if (stb_fall) begin
            state_next = S_CMD;
        end else begin
            case (state)
                S_CMD: begin
                    if (byte_done) begin
                        cmd_done = 1'b1;
                        case (byte_val[7:6])
                            2'b01:   state_next = byte_val[1] ? S_RDATA : S_IGNORE;
                            2'b11:   state_next = S_WDATA;
                            default: state_next = S_IGNORE;
                        endcase
                    end
                end
                S_WDATA: wr_en   = byte_done;
                S_RDATA: rd_fall = clk_fall;
                default: ;
            endcase
        end
    end

    // Read mode only selects the state after the data command; fixed-address
    // mode persists across strobes until the next data command.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            ptr        <= '0;
            fixed_mode <= 1'b0;
            display_on <= 1'b0;
            brightness <= '0;
            cmd_error  <= 1'b0;
            key_idx    <= '0;
            rd_bit     <= '0;
            rd_shift   <= '0;
            out_en     <= 1'b0;
            data_bit   <= 1'b0;
            for (int n = 0; n < 16; n++) ram[n] <= '0;
        end else begin
            cmd_error <= 1'b0;
            if (stb_rise || stb_fall) begin
                bit_cnt  <= '0;
                out_en   <= 1'b0;
                data_bit <= 1'b0;
            end else begin
                if (clk_rise && state != S_IDLE) begin
                    rx_shift <= byte_val[7:1];
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (cmd_done) begin
                    case (byte_val[7:6])
                        2'b01: begin
                            fixed_mode <= byte_val[2];
                            key_idx    <= '0;
                            rd_bit     <= '0;
                        end
                        2'b11: ptr <= byte_val[3:0];
                        2'b10: begin
                            display_on <= byte_val[3];
                            brightness <= byte_val[2:0];
                        end
                        default: cmd_error <= 1'b1;
                    endcase
                end
                if (wr_en) begin
                    ram[ptr] <= byte_val;
                    if (!fixed_mode) ptr <= ptr + 4'd1;
                end
                // First fall of each read byte loads the key byte; later falls
                // shift it out. Index saturates at 4, which reads as zero.
                if (rd_fall) begin
                    out_en <= 1'b1;
                    if (rd_bit == 3'd0) begin
                        data_bit <= cur_key[0];
                        rd_shift <= cur_key[7:1];
                    end else begin
                        data_bit <= rd_shift[0];
                        rd_shift <= {1'b0, rd_shift[6:1]};
                    end
                    rd_bit <= rd_bit + 3'd1;
                    if (rd_bit == 3'd7 && key_idx != 3'd4) key_idx <= key_idx + 3'd1;
                end
            end
        end
    end

    assign sio_data_out_en = out_en;
    assign sio_data_out    = out_en & data_bit;

    always_comb begin
        display_ram = '0;
        for (int n = 0; n < 16; n++) display_ram[8*n +: 8] = ram[n];
    end

endmodule
